control_sequencer: RTL and testbench

Parametrised multi-cycle control unit for the CPU. It owns the fetch/execute state machine and combines it with instruction-class decode to drive the datapath strobes. Compared with the purely combinational decoder it adds variable-length execution (1–3 exec cycles per class), a memory wait-state handshake and a halt/run mode. It sits between the instruction register output and the PC, IR, register file, status register and RAM controls.

---
 rtl/control_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle fetch/execute control unit. It combines a small state machine
// (FETCH, EXEC1..EXEC3, HALT) with instruction-class decode and drives the
// datapath strobes for the PC, IR, register file, status register and RAM.
// Each class runs for 1 to 3 exec cycles. Memory wait states are honoured
// through mem_ready. A stp instruction parks the unit in HALT until run is
// asserted.
//
// Parameters
//   INSTR_W   instruction width (16..32). Decode fields come from the MSB end.
//   STALL_EN  1: wait cycles hold until mem_ready is high.
//             0: mem_ready is ignored and treated as 1.
//
// Ports
//   clk                  system clock, rising edge
//   reset                synchronous, active-high reset
//   instruction          IR contents
//   mem_ready            RAM access completes this cycle
//   run                  leave HALT
//   cycle_state          0 FETCH, 1 EXEC1, 2 EXEC2, 3 EXEC3, 4 HALT
//   ir_en                IR load
//   pc_cnt_en            PC increment
//   pc_sload             PC parallel load
//   ram_instr_addr_sel   instruction RAM address source (0 = PC)
//   ram_data_addr_sel    data RAM address source (1 = SP/operand)
//   ram_wren_data        data RAM write enable
//   reg_wren             register-file write
//   status_reg_sload     status-register load
//   sm_extra             exec cycle that is not the last one for the class
//   halted               unit is in HALT
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int INSTR_W  = 16,
  parameter bit STALL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ready,
  input  logic               run,
  output logic [2:0]         cycle_state,
  output logic               ir_en,
  output logic               pc_cnt_en,
  output logic               pc_sload,
  output logic               ram_instr_addr_sel,
  output logic               ram_data_addr_sel,
  output logic               ram_wren_data,
  output logic               reg_wren,
  output logic               status_reg_sload,
  output logic               sm_extra,
  output logic               halted
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC1 = 3'd1;
  localparam logic [2:0] S_EXEC2 = 3'd2;
  localparam logic [2:0] S_EXEC3 = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [3:0] C_ALU   = 4'd0;
  localparam logic [3:0] C_LDA   = 4'd1;
  localparam logic [3:0] C_CALL  = 4'd2;
  localparam logic [3:0] C_JMD   = 4'd3;
  localparam logic [3:0] C_RTN   = 4'd4;
  localparam logic [3:0] C_STP   = 4'd5;
  localparam logic [3:0] C_PUSH  = 4'd6;
  localparam logic [3:0] C_POP   = 4'd7;
  localparam logic [3:0] C_STORE = 4'd8;

  logic [2:0] state_q, state_d;
  logic [3:0] class_q, class_d;

  logic [3:0] op;
  logic [1:0] sub;
  logic       z7;
  logic       stp_bit;
  logic [3:0] dec_class;
  logic [1:0] n_exec;
  logic       wait_cycle;
  logic       ready;
  logic       last_exec;

  // Low-order operand bits carry no control information.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[INSTR_W-13:0];

  // Instruction-class decode from the MSB end of the word.
  always_comb begin
    op        = instruction[INSTR_W-1 -: 4];
    sub       = instruction[INSTR_W-5 -: 2];
    z7        = (instruction[INSTR_W-5 -: 7] == 7'd0);
    stp_bit   = instruction[INSTR_W-12];
    dec_class = C_ALU;
    case (op)
      4'b1110: dec_class = C_LDA;
      4'b1101: dec_class = C_CALL;
      4'b1100: dec_class = C_JMD;
      4'b1111: begin
        if (z7) begin
          dec_class = stp_bit ? C_STP : C_RTN;
        end
      end
      4'b0110: begin
        case (sub)
          2'b00:   dec_class = C_PUSH;
          2'b10:   dec_class = C_POP;
          2'b11:   dec_class = C_STORE;
          default: dec_class = C_ALU;
        endcase
      end
      default: dec_class = C_ALU;
    endcase
  end

  // Exec-cycle count of the latched class.
  always_comb begin
    case (class_q)
      C_LDA:                                   n_exec = 2'd3;
      C_CALL, C_RTN, C_PUSH, C_POP, C_STORE:   n_exec = 2'd2;
      default:                                 n_exec = 2'd1;
    endcase
  end

  // Only FETCH and the memory-read/write EXEC2 cycles can be stretched.
  always_comb begin
    wait_cycle = 1'b0;
    if (state_q == S_FETCH) begin
      wait_cycle = 1'b1;
    end else if (state_q == S_EXEC2) begin
      wait_cycle = (class_q == C_RTN) || (class_q == C_POP) ||
                   (class_q == C_STORE) || (class_q == C_LDA);
    end
    ready = (STALL_EN && wait_cycle) ? mem_ready : 1'b1;
  end

  always_comb begin
    last_exec = ((state_q == S_EXEC1) && (n_exec == 2'd1)) ||
                ((state_q == S_EXEC2) && (n_exec == 2'd2)) ||
                 (state_q == S_EXEC3);
  end

  // Next-state logic. The class is captured once, on the FETCH->EXEC1 edge,
  // and used unchanged for the rest of the instruction.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_FETCH: begin
        if (ready) begin
          state_d = S_EXEC1;
          class_d = dec_class;
        end
      end
      S_EXEC1: begin
        if (class_q == C_STP) begin
          state_d = S_HALT;
        end else if (n_exec > 2'd1) begin
          state_d = S_EXEC2;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC2: begin
        if (ready) begin
          state_d = (n_exec > 2'd2) ? S_EXEC3 : S_FETCH;
        end
      end
      S_EXEC3: state_d = S_FETCH;
      S_HALT: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      class_q <= C_ALU;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  // Strobe generation. Everything is forced low while reset is high so that
  // an aborted instruction cannot fire a strobe in the reset cycle.
  always_comb begin
    cycle_state        = 3'd0;
    ir_en              = 1'b0;
    pc_cnt_en          = 1'b0;
    pc_sload           = 1'b0;
    ram_instr_addr_sel = 1'b0;
    ram_data_addr_sel  = 1'b0;
    ram_wren_data      = 1'b0;
    reg_wren           = 1'b0;
    status_reg_sload   = 1'b0;
    sm_extra           = 1'b0;
    halted             = 1'b0;
    if (!reset) begin
      cycle_state = state_q;
      case (state_q)
        S_FETCH: begin
          ir_en     = ready;
          pc_cnt_en = ready;
        end
        S_EXEC1: begin
          sm_extra = !last_exec;
          case (class_q)
            C_ALU: begin
              reg_wren         = 1'b1;
              status_reg_sload = 1'b1;
            end
            C_JMD: pc_sload = 1'b1;
            C_CALL, C_PUSH: begin
              ram_data_addr_sel = 1'b1;
              ram_wren_data     = 1'b1;
            end
            C_RTN, C_POP, C_STORE, C_LDA: ram_data_addr_sel = 1'b1;
            default: ;
          endcase
        end
        S_EXEC2: begin
          sm_extra = !last_exec;
          case (class_q)
            C_CALL: pc_sload = 1'b1;
            C_RTN: begin
              ram_data_addr_sel = 1'b1;
              pc_sload          = ready;
            end
            C_PUSH: reg_wren = 1'b1;
            C_POP: begin
              ram_data_addr_sel = 1'b1;
              reg_wren          = ready;
            end
            C_STORE: begin
              ram_data_addr_sel = 1'b1;
              ram_wren_data     = 1'b1;
            end
            C_LDA: ram_data_addr_sel = 1'b1;
            default: ;
          endcase
        end
        S_EXEC3: begin
          sm_extra = !last_exec;
          if (class_q == C_LDA) begin
            reg_wren = 1'b1;
          end
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench for control_sequencer. Two instances are exercised one after
// the other: A (INSTR_W=16, STALL_EN=1) and B (INSTR_W=24, STALL_EN=0).
// Each step drives one cycle of inputs, pushes the expected output vector to a
// scoreboard queue, then pops and compares it mid-cycle.
//
// Expected vector layout: {cycle_state[2:0], ir_en, pc_cnt_en, pc_sload,
// ram_instr_addr_sel, ram_data_addr_sel, ram_wren_data, reg_wren,
// status_reg_sload, sm_extra, halted}.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  localparam logic [9:0] F_NONE = 10'b00_0000_0000;
  localparam logic [9:0] F_IR   = 10'b10_0000_0000;
  localparam logic [9:0] F_PCC  = 10'b01_0000_0000;
  localparam logic [9:0] F_PCS  = 10'b00_1000_0000;
  localparam logic [9:0] F_DAS  = 10'b00_0010_0000;
  localparam logic [9:0] F_WR   = 10'b00_0001_0000;
  localparam logic [9:0] F_RW   = 10'b00_0000_1000;
  localparam logic [9:0] F_SS   = 10'b00_0000_0100;
  localparam logic [9:0] F_EX   = 10'b00_0000_0010;
  localparam logic [9:0] F_HL   = 10'b00_0000_0001;
  localparam logic [9:0] F_FET  = F_IR | F_PCC;

  localparam bit DA = 1'b0;
  localparam bit DB = 1'b1;

  typedef struct {
    string       tag;
    logic [12:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        reset_a = 1'b1, mem_ready_a = 1'b1, run_a = 1'b0;
  logic [15:0] instr_a = 16'h0000;
  logic [2:0]  cs_a;
  logic        ir_en_a, pc_cnt_en_a, pc_sload_a, ias_a, das_a, wr_a, rw_a, ss_a, ex_a, hl_a;

  // Instance B signals
  logic        reset_b = 1'b1, mem_ready_b = 1'b0, run_b = 1'b0;
  logic [23:0] instr_b = 24'h000000;
  logic [2:0]  cs_b;
  logic        ir_en_b, pc_cnt_en_b, pc_sload_b, ias_b, das_b, wr_b, rw_b, ss_b, ex_b, hl_b;

  control_sequencer #(.INSTR_W(16), .STALL_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .instruction(instr_a), .mem_ready(mem_ready_a), .run(run_a),
    .cycle_state(cs_a), .ir_en(ir_en_a), .pc_cnt_en(pc_cnt_en_a), .pc_sload(pc_sload_a),
    .ram_instr_addr_sel(ias_a), .ram_data_addr_sel(das_a), .ram_wren_data(wr_a),
    .reg_wren(rw_a), .status_reg_sload(ss_a), .sm_extra(ex_a), .halted(hl_a)
  );

  control_sequencer #(.INSTR_W(24), .STALL_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .instruction(instr_b), .mem_ready(mem_ready_b), .run(run_b),
    .cycle_state(cs_b), .ir_en(ir_en_b), .pc_cnt_en(pc_cnt_en_b), .pc_sload(pc_sload_b),
    .ram_instr_addr_sel(ias_b), .ram_data_addr_sel(das_b), .ram_wren_data(wr_b),
    .reg_wren(rw_b), .status_reg_sload(ss_b), .sm_extra(ex_b), .halted(hl_b)
  );

  logic [12:0] obs_a, obs_b;
  assign obs_a = {cs_a, ir_en_a, pc_cnt_en_a, pc_sload_a, ias_a, das_a, wr_a, rw_a, ss_a, ex_a, hl_a};
  assign obs_b = {cs_b, ir_en_b, pc_cnt_en_b, pc_sload_b, ias_b, das_b, wr_b, rw_b, ss_b, ex_b, hl_b};

  task automatic check(input bit sel);
    sb_t         e;
    logic [12:0] obs;
    obs = sel ? obs_b : obs_a;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock cycle: drive inputs just after the edge, record the expected
  // outputs for this cycle, then compare mid-cycle.
  task automatic step(input string tag, input bit sel, input logic rst, input logic run_i,
                      input logic mr, input logic [23:0] instr,
                      input logic [2:0] st, input logic [9:0] fl);
    sb_t e;
    @(posedge clk);
    #1;
    if (sel == DA) begin
      reset_a = rst; run_a = run_i; mem_ready_a = mr; instr_a = instr[15:0];
    end else begin
      reset_b = rst; run_b = run_i; mem_ready_b = mr; instr_b = instr;
    end
    e.tag = tag;
    e.exp = {st, fl};
    sb_q.push_back(e);
    #3;
    check(sel);
  endtask

  initial begin
    // ---------------- instance A: INSTR_W=16, STALL_EN=1 ----------------
    step("a_rst0",    DA, 1, 0, 1, 24'h4000, 3'd0, F_NONE);
    step("a_rst1",    DA, 1, 1, 1, 24'h4000, 3'd0, F_NONE);
    // alu
    step("alu_f",     DA, 0, 0, 1, 24'h4000, 3'd0, F_FET);
    step("alu_e1",    DA, 0, 0, 1, 24'h4000, 3'd1, F_RW | F_SS);
    // lda with two wait cycles in EXEC2
    step("lda_f",     DA, 0, 0, 1, 24'hE123, 3'd0, F_FET);
    step("lda_e1",    DA, 0, 0, 1, 24'hE123, 3'd1, F_DAS | F_EX);
    step("lda_e2w0",  DA, 0, 0, 0, 24'hE123, 3'd2, F_DAS | F_EX);
    step("lda_e2w1",  DA, 0, 0, 0, 24'hE123, 3'd2, F_DAS | F_EX);
    step("lda_e2",    DA, 0, 0, 1, 24'hE123, 3'd2, F_DAS | F_EX);
    step("lda_e3",    DA, 0, 0, 1, 24'hE123, 3'd3, F_RW);
    // fetch stall then call
    step("fetch_wait",DA, 0, 0, 0, 24'hD010, 3'd0, F_NONE);
    step("call_f",    DA, 0, 0, 1, 24'hD010, 3'd0, F_FET);
    step("call_e1",   DA, 0, 0, 1, 24'hD010, 3'd1, F_DAS | F_WR | F_EX);
    step("call_e2",   DA, 0, 0, 1, 24'hD010, 3'd2, F_PCS);
    // jmd
    step("jmd_f",     DA, 0, 0, 1, 24'hC010, 3'd0, F_FET);
    step("jmd_e1",    DA, 0, 0, 1, 24'hC010, 3'd1, F_PCS);
    // rtn with one wait cycle
    step("rtn_f",     DA, 0, 0, 1, 24'hF000, 3'd0, F_FET);
    step("rtn_e1",    DA, 0, 0, 1, 24'hF000, 3'd1, F_DAS | F_EX);
    step("rtn_e2w",   DA, 0, 0, 0, 24'hF000, 3'd2, F_DAS);
    step("rtn_e2",    DA, 0, 0, 1, 24'hF000, 3'd2, F_DAS | F_PCS);
    // stp -> HALT held 5 cycles, then run
    step("stp_f",     DA, 0, 0, 1, 24'hF010, 3'd0, F_FET);
    step("stp_e1",    DA, 0, 0, 1, 24'hF010, 3'd1, F_NONE);
    for (int i = 0; i < 5; i++) begin
      step("halt_hold", DA, 0, 0, i[0], 24'hF010, 3'd4, F_HL);
    end
    step("halt_run",  DA, 0, 1, 1, 24'hF010, 3'd4, F_HL);
    // run outside HALT is ignored
    step("run_ign_f", DA, 0, 1, 1, 24'hF010, 3'd0, F_FET);
    step("stp_e1b",   DA, 0, 1, 1, 24'hF010, 3'd1, F_NONE);
    step("halt2",     DA, 0, 0, 1, 24'hF010, 3'd4, F_HL);
    // reset and run together: reset wins, outputs all low
    step("rst_run",   DA, 1, 1, 1, 24'h6C00, 3'd0, F_NONE);
    // store with reset in the held EXEC2 cycle
    step("st_f",      DA, 0, 0, 1, 24'h6C00, 3'd0, F_FET);
    step("st_e1",     DA, 0, 0, 1, 24'h6C00, 3'd1, F_DAS | F_EX);
    step("st_e2w",    DA, 0, 0, 0, 24'h6C00, 3'd2, F_DAS | F_WR);
    step("st_rst",    DA, 1, 0, 0, 24'h6C00, 3'd0, F_NONE);
    step("st_after",  DA, 0, 0, 1, 24'h4000, 3'd0, F_FET);
    step("alu_e1b",   DA, 0, 0, 1, 24'h4000, 3'd1, F_RW | F_SS);
    // push
    step("push_f",    DA, 0, 0, 1, 24'h6000, 3'd0, F_FET);
    step("push_e1",   DA, 0, 0, 1, 24'h6000, 3'd1, F_DAS | F_WR | F_EX);
    step("push_e2",   DA, 0, 0, 1, 24'h6000, 3'd2, F_RW);
    // pop with one wait cycle
    step("pop_f",     DA, 0, 0, 1, 24'h6800, 3'd0, F_FET);
    step("pop_e1",    DA, 0, 0, 1, 24'h6800, 3'd1, F_DAS | F_EX);
    step("pop_e2w",   DA, 0, 0, 0, 24'h6800, 3'd2, F_DAS);
    step("pop_e2",    DA, 0, 0, 1, 24'h6800, 3'd2, F_DAS | F_RW);
    // op 0110 sub 01 and op 1111 without z7 fall back to alu
    step("alu01_f",   DA, 0, 0, 1, 24'h6400, 3'd0, F_FET);
    step("alu01_e1",  DA, 0, 0, 1, 24'h6400, 3'd1, F_RW | F_SS);
    step("aluF1_f",   DA, 0, 0, 1, 24'hF100, 3'd0, F_FET);
    step("aluF1_e1",  DA, 0, 0, 1, 24'hF100, 3'd1, F_RW | F_SS);
    step("a_park",    DA, 1, 0, 1, 24'h0000, 3'd0, F_NONE);

    // ---------------- instance B: INSTR_W=24, STALL_EN=0 ----------------
    step("b_rst",     DB, 1, 0, 0, 24'hF01000, 3'd0, F_NONE);
    step("b_stp_f",   DB, 0, 0, 0, 24'hF01000, 3'd0, F_FET);
    step("b_stp_e1",  DB, 0, 0, 0, 24'hF01000, 3'd1, F_NONE);
    step("b_halt",    DB, 0, 0, 0, 24'hF01000, 3'd4, F_HL);
    step("b_halt_run",DB, 0, 1, 0, 24'hF01000, 3'd4, F_HL);
    // lda with mem_ready stuck low still takes 4 cycles
    step("b_lda_f",   DB, 0, 0, 0, 24'hE12300, 3'd0, F_FET);
    step("b_lda_e1",  DB, 0, 0, 0, 24'hE12300, 3'd1, F_DAS | F_EX);
    step("b_lda_e2",  DB, 0, 0, 0, 24'hE12300, 3'd2, F_DAS | F_EX);
    step("b_lda_e3",  DB, 0, 0, 0, 24'hE12300, 3'd3, F_RW);
    step("b_alu_f",   DB, 0, 0, 0, 24'h400000, 3'd0, F_FET);
    step("b_alu_e1",  DB, 0, 0, 0, 24'h400000, 3'd1, F_RW | F_SS);
    step("b_rtn_f",   DB, 0, 0, 0, 24'hF00000, 3'd0, F_FET);
    step("b_rtn_e1",  DB, 0, 0, 0, 24'hF00000, 3'd1, F_DAS | F_EX);
    step("b_rtn_e2",  DB, 0, 0, 0, 24'hF00000, 3'd2, F_DAS | F_PCS);
    step("b_back",    DB, 0, 0, 0, 24'h400000, 3'd0, F_FET);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
